// File: rtl/line_buffer_fifo_bank_pkg.sv
// Shared sizing for the three-row line buffer bank and the write/read FIFO control FSM.
// Both sides import this package so that their pointer and count widths stay in step.
package line_buffer_fifo_bank_pkg;

    localparam int LB_DATA_WIDTH = 16;
    localparam int LB_DEPTH      = 64;
    localparam int LB_NUM_FIFOS  = 3;
    localparam int LB_PTR_W      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam int LB_CNT_W      = $clog2(LB_DEPTH + 1);

endpackage

// File: rtl/sync_fifo.sv
// One line-buffer row FIFO: memory, pointers, occupancy count, sticky error flags and
// a registered read port. A read is a single-cycle request; rd_vld marks the data it returns.
module sync_fifo
    import line_buffer_fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH = LB_DATA_WIDTH,
    parameter int DEPTH      = LB_DEPTH
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  err_clr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_vld,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf,
    output logic                  udf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic wr_ok, rd_ok, ovf_evt, udf_evt;

    always_comb begin
        full  = (cnt_q == CNT_FULL);
        empty = (cnt_q == '0);

        // A full FIFO still takes a write when a read frees a slot in the same cycle;
        // an empty FIFO never forwards din straight to the read port.
        rd_ok   = rd_en & ~clr & ~empty;
        wr_ok   = wr_en & ~clr & (~full | rd_ok);
        ovf_evt = wr_en & ~clr & full & ~rd_ok;
        udf_evt = rd_en & ~clr & empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        rd_vld_d = rd_ok;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
                dout_d   = mem[rd_ptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // A fresh error in the same cycle as err_clr keeps the flag set.
        ovf_d = (ovf_q & ~err_clr) | ovf_evt;
        udf_d = (udf_q & ~err_clr) | udf_evt;
    end

    always_ff @(posedge clk1) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            rd_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rd_vld_q <= rd_vld_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign dout   = dout_q;
    assign rd_vld = rd_vld_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule

// File: rtl/line_buffer_fifo_bank.sv
// Bank of three row FIFOs sharing one pixel input. Either side's flush request clears
// all three rows at once; everything else is per-row wiring.
module line_buffer_fifo_bank
    import line_buffer_fifo_bank_pkg::*;
#(
    parameter int DATA_WIDTH = LB_DATA_WIDTH,
    parameter int DEPTH      = LB_DEPTH
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  wr_en_0,
    input  logic                  wr_en_1,
    input  logic                  wr_en_2,
    input  logic                  rd_en_0,
    input  logic                  rd_en_1,
    input  logic                  rd_en_2,
    input  logic                  wr_clr,
    input  logic                  rd_clr,
    input  logic                  err_clr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout_0,
    output logic [DATA_WIDTH-1:0] dout_1,
    output logic [DATA_WIDTH-1:0] dout_2,
    output logic                  rd_vld_0,
    output logic                  rd_vld_1,
    output logic                  rd_vld_2,
    output logic [2:0]            full,
    output logic [2:0]            empty,
    output logic [2:0]            ovf,
    output logic [2:0]            udf
);

    logic                  flush;
    logic [2:0]            wr_en_v;
    logic [2:0]            rd_en_v;
    logic [2:0]            rd_vld_v;
    logic [DATA_WIDTH-1:0] dout_v [LB_NUM_FIFOS];

    assign flush   = wr_clr | rd_clr;
    assign wr_en_v = {wr_en_2, wr_en_1, wr_en_0};
    assign rd_en_v = {rd_en_2, rd_en_1, rd_en_0};

    for (genvar i = 0; i < LB_NUM_FIFOS; i++) begin : g_fifo
        sync_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk1    (clk1),
            .rst_n   (rst_n),
            .clr     (flush),
            .err_clr (err_clr),
            .wr_en   (wr_en_v[i]),
            .rd_en   (rd_en_v[i]),
            .din     (din),
            .dout    (dout_v[i]),
            .rd_vld  (rd_vld_v[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .ovf     (ovf[i]),
            .udf     (udf[i])
        );
    end

    assign dout_0   = dout_v[0];
    assign dout_1   = dout_v[1];
    assign dout_2   = dout_v[2];
    assign rd_vld_0 = rd_vld_v[0];
    assign rd_vld_1 = rd_vld_v[1];
    assign rd_vld_2 = rd_vld_v[2];

endmodule

// File: tb/tb_line_buffer_fifo_bank.sv
// Directed bench for the three-row line buffer bank: a vector table for short mixed
// sequences, then hand-written fill/drain, overflow, staggered-row, flush and reset cases.
module tb_line_buffer_fifo_bank;

    localparam int W = 16;
    localparam int D = 64;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en_0 = 1'b0, wr_en_1 = 1'b0, wr_en_2 = 1'b0;
    logic          rd_en_0 = 1'b0, rd_en_1 = 1'b0, rd_en_2 = 1'b0;
    logic          wr_clr = 1'b0, rd_clr = 1'b0, err_clr = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout_0, dout_1, dout_2;
    logic          rd_vld_0, rd_vld_1, rd_vld_2;
    logic [2:0]    full, empty, ovf, udf;

    logic [W-1:0]  dout_a [3];
    logic [2:0]    vld_a;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q [$];

    typedef struct {
        logic [2:0]   wr;
        logic [2:0]   rd;
        logic         wclr;
        logic         rclr;
        logic         eclr;
        logic [W-1:0] din;
        logic [2:0]   e_vld;
        logic [W-1:0] e_dout;
        logic [2:0]   e_full;
        logic [2:0]   e_empty;
        logic [2:0]   e_ovf;
        logic [2:0]   e_udf;
    } vec_t;

    vec_t vecs [12];

    line_buffer_fifo_bank #(.DATA_WIDTH(W), .DEPTH(D)) dut (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .wr_en_0  (wr_en_0),
        .wr_en_1  (wr_en_1),
        .wr_en_2  (wr_en_2),
        .rd_en_0  (rd_en_0),
        .rd_en_1  (rd_en_1),
        .rd_en_2  (rd_en_2),
        .wr_clr   (wr_clr),
        .rd_clr   (rd_clr),
        .err_clr  (err_clr),
        .din      (din),
        .dout_0   (dout_0),
        .dout_1   (dout_1),
        .dout_2   (dout_2),
        .rd_vld_0 (rd_vld_0),
        .rd_vld_1 (rd_vld_1),
        .rd_vld_2 (rd_vld_2),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .udf      (udf)
    );

    // Clock and watchdog
    always #5 clk1 = ~clk1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    assign dout_a[0] = dout_0;
    assign dout_a[1] = dout_1;
    assign dout_a[2] = dout_2;
    assign vld_a     = {rd_vld_2, rd_vld_1, rd_vld_0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change after the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic [2:0] wr, input logic [2:0] rd, input logic wclr,
                         input logic rclr, input logic eclr, input logic [W-1:0] d);
        @(negedge clk1);
        {wr_en_2, wr_en_1, wr_en_0} = wr;
        {rd_en_2, rd_en_1, rd_en_0} = rd;
        wr_clr  = wclr;
        rd_clr  = rclr;
        err_clr = eclr;
        din     = d;
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, '0);
    endtask

    function automatic vec_t mk(logic [2:0] wr, logic [2:0] rd, logic wclr, logic rclr,
                                logic eclr, logic [W-1:0] d, logic [2:0] e_vld,
                                logic [W-1:0] e_dout, logic [2:0] e_full,
                                logic [2:0] e_empty, logic [2:0] e_ovf, logic [2:0] e_udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.wclr = wclr; v.rclr = rclr; v.eclr = eclr; v.din = d;
        v.e_vld = e_vld; v.e_dout = e_dout; v.e_full = e_full; v.e_empty = e_empty;
        v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    initial begin
        //             wr      rd    wc rc ec din      vld     dout     full    empty   ovf     udf
        vecs[0]  = mk(3'b001, 3'b000, 0, 0, 0, 16'h0011, 3'b000, 16'h0000, 3'b000, 3'b110, 3'b000, 3'b000);
        vecs[1]  = mk(3'b011, 3'b000, 0, 0, 0, 16'h0022, 3'b000, 16'h0000, 3'b000, 3'b100, 3'b000, 3'b000);
        vecs[2]  = mk(3'b000, 3'b001, 0, 0, 0, 16'h0000, 3'b001, 16'h0011, 3'b000, 3'b100, 3'b000, 3'b000);
        vecs[3]  = mk(3'b100, 3'b011, 0, 0, 0, 16'h0033, 3'b011, 16'h0022, 3'b000, 3'b011, 3'b000, 3'b000);
        vecs[4]  = mk(3'b000, 3'b011, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 3'b000, 3'b011, 3'b000, 3'b011);
        vecs[5]  = mk(3'b100, 3'b100, 0, 0, 0, 16'h0044, 3'b100, 16'h0033, 3'b000, 3'b011, 3'b000, 3'b011);
        vecs[6]  = mk(3'b000, 3'b001, 0, 0, 1, 16'h0000, 3'b000, 16'h0000, 3'b000, 3'b011, 3'b000, 3'b001);
        vecs[7]  = mk(3'b001, 3'b001, 0, 0, 0, 16'h0055, 3'b000, 16'h0000, 3'b000, 3'b010, 3'b000, 3'b001);
        vecs[8]  = mk(3'b000, 3'b000, 0, 0, 1, 16'h0000, 3'b000, 16'h0000, 3'b000, 3'b010, 3'b000, 3'b000);
        vecs[9]  = mk(3'b111, 3'b111, 1, 0, 0, 16'h0066, 3'b000, 16'h0000, 3'b000, 3'b111, 3'b000, 3'b000);
        vecs[10] = mk(3'b000, 3'b001, 0, 0, 0, 16'h0000, 3'b000, 16'h0000, 3'b000, 3'b111, 3'b000, 3'b001);
        vecs[11] = mk(3'b000, 3'b000, 0, 0, 1, 16'h0000, 3'b000, 16'h0000, 3'b000, 3'b111, 3'b000, 3'b000);

        // Reset values
        #12;
        check("rst_empty", 32'(empty), 32'h7);
        check("rst_full", 32'(full), 32'h0);
        check("rst_vld", 32'(vld_a), 32'h0);
        check("rst_dout0", 32'(dout_0), 32'h0);
        check("rst_err", 32'({ovf, udf}), 32'h0);
        @(negedge clk1);
        rst_n = 1'b1;

        // Table-driven short sequences
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].wclr, vecs[i].rclr, vecs[i].eclr, vecs[i].din);
            check($sformatf("vec%0d_vld", i), 32'(vld_a), 32'(vecs[i].e_vld));
            check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
            check($sformatf("vec%0d_udf", i), 32'(udf), 32'(vecs[i].e_udf));
            for (int f = 0; f < 3; f++) begin
                if (vecs[i].e_vld[f]) begin
                    check($sformatf("vec%0d_dout%0d", i, f), 32'(dout_a[f]), 32'(vecs[i].e_dout));
                end
            end
        end
        check("hold_dout0", 32'(dout_0), 32'h0022);
        check("hold_dout1", 32'(dout_1), 32'h0022);
        check("hold_dout2", 32'(dout_2), 32'h0033);

        // Fill/drain FIFO0
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b1, '0);
        exp_q.delete();
        for (int i = 0; i < D; i++) begin
            drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, W'(i));
            exp_q.push_back(W'(i));
            if (i == D - 2) check("fill_not_full", 32'(full[0]), 32'h0);
            if (i == D - 1) check("fill_full", 32'(full[0]), 32'h1);
        end
        for (int i = 0; i < D; i++) begin
            drive(3'b000, 3'b001, 1'b0, 1'b0, 1'b0, '0);
            check("drain_vld", 32'(rd_vld_0), 32'h1);
            check("drain_dout", 32'(dout_0), 32'(exp_q.pop_front()));
        end
        check("drain_empty", 32'(empty[0]), 32'h1);
        check("drain_udf", 32'(udf[0]), 32'h0);

        // Overflow, then full write accepted alongside a read
        for (int i = 0; i < D; i++) begin
            drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, W'(100 + i));
            exp_q.push_back(W'(100 + i));
        end
        drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 16'hDEAD);
        check("ovf_set", 32'(ovf[0]), 32'h1);
        check("ovf_full", 32'(full[0]), 32'h1);
        check("ovf_vld", 32'(rd_vld_0), 32'h0);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, '0);
        check("ovf_clr", 32'(ovf[0]), 32'h0);
        drive(3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 16'hBEEF);
        exp_q.push_back(16'hBEEF);
        check("wr_rd_full_vld", 32'(rd_vld_0), 32'h1);
        check("wr_rd_full_dout", 32'(dout_0), 32'(exp_q.pop_front()));
        check("wr_rd_full_ovf", 32'(ovf[0]), 32'h0);
        check("wr_rd_full_full", 32'(full[0]), 32'h1);
        for (int i = 0; i < D; i++) begin
            drive(3'b000, 3'b001, 1'b0, 1'b0, 1'b0, '0);
            check("ovf_drain_dout", 32'(dout_0), 32'(exp_q.pop_front()));
        end
        check("ovf_drain_empty", 32'(empty[0]), 32'h1);

        // Staggered rows
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b1, '0);
        for (int c = 0; c < 124; c++) begin
            drive((c < 62) ? 3'b001 : 3'b011, 3'b000, 1'b0, 1'b0, 1'b0, W'(c));
        end
        check("stag_full0", 32'(full[0]), 32'h1);
        check("stag_ovf0", 32'(ovf[0]), 32'h1);
        check("stag_full1", 32'(full[1]), 32'h0);
        check("stag_empty1", 32'(empty[1]), 32'h0);
        check("stag_empty2", 32'(empty[2]), 32'h1);
        for (int k = 0; k < 62; k++) begin
            drive(3'b000, 3'b010, 1'b0, 1'b0, 1'b0, '0);
            check("stag_rd1_vld", 32'(rd_vld_1), 32'h1);
            check("stag_rd1_dout", 32'(dout_1), 32'(62 + k));
        end
        check("stag_empty1_end", 32'(empty[1]), 32'h1);
        check("stag_udf1", 32'(udf[1]), 32'h0);

        // Flush priority over simultaneous access
        drive(3'b000, 3'b000, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 10; i++) drive(3'b100, 3'b000, 1'b0, 1'b0, 1'b0, W'(300 + i));
        check("fl_pre_empty2", 32'(empty[2]), 32'h0);
        drive(3'b100, 3'b100, 1'b0, 1'b1, 1'b0, 16'h1234);
        check("fl_empty2", 32'(empty[2]), 32'h1);
        check("fl_vld2", 32'(rd_vld_2), 32'h0);
        check("fl_ovf", 32'(ovf), 32'h0);
        check("fl_udf", 32'(udf), 32'h0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 32; i++) drive(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, W'(200 + i));
        drive(3'b000, 3'b001, 1'b0, 1'b0, 1'b0, '0);
        check("ar_pre_vld", 32'(rd_vld_0), 32'h1);
        check("ar_pre_dout", 32'(dout_0), 32'd200);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_empty", 32'(empty), 32'h7);
        check("ar_full", 32'(full), 32'h0);
        check("ar_vld", 32'(vld_a), 32'h0);
        check("ar_dout0", 32'(dout_0), 32'h0);
        check("ar_err", 32'({ovf, udf}), 32'h0);
        @(negedge clk1);
        {rd_en_2, rd_en_1, rd_en_0} = 3'b000;
        rst_n = 1'b1;
        drive(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 16'h0077);
        drive(3'b000, 3'b010, 1'b0, 1'b0, 1'b0, '0);
        check("ar_post_vld", 32'(rd_vld_1), 32'h1);
        check("ar_post_dout", 32'(dout_1), 32'h0077);
        idle();
        check("ar_post_empty", 32'(empty), 32'h7);
        check("ar_post_vld_idle", 32'(vld_a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
